// File: rtl/rubik_sequencer_if.sv
// Program-write handshake between a move source and rubik_sequencer.
interface rubik_sequencer_if;
    logic       wr_valid_i;
    logic [3:0] wr_data_i;
    logic       wr_ready_o;

    modport master (
        output wr_valid_i,
        output wr_data_i,
        input  wr_ready_o
    );

    modport slave (
        input  wr_valid_i,
        input  wr_data_i,
        output wr_ready_o
    );
endinterface

// File: rtl/rubik_sequencer.sv
// Move-program sequencer for the cube datapath: buffers up to DEPTH move
// codes and replays them one per cycle on cube_cmd_o, reporting whether the
// cube ended up solved.
// Optional feature: define RUBIK_SEQ_REPEAT_EN to replay the program up to
// MAX_LOOPS times per start and expose the pass count on loops_o.
module rubik_sequencer #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned MAX_LOOPS = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    rubik_sequencer_if.slave wr_bus,
    input  logic             clear_i,
    input  logic             start_i,
    output logic [3:0]       cube_cmd_o,
    input  logic             cube_done_i,
    output logic             busy_o,
    output logic             finish_o,
    output logic             solved_o,
    output logic [7:0]       moves_o,
    output logic [4:0]       len_o
`ifdef RUBIK_SEQ_REPEAT_EN
    ,
    output logic [3:0]       loops_o
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SETTLE
    } state_t;

    state_t     state;
    logic [3:0] mem [DEPTH];
    logic [4:0] idx;          // index of the next move to load
    logic       wr_acc;
    logic [4:0] prog_len;     // program length as seen by a same-cycle start
    logic [3:0] first_move;

    function automatic logic [7:0] count_move(input logic [7:0] m, input logic [3:0] c);
        return (c != 4'h0 && m != 8'hFF) ? m + 8'd1 : m;
    endfunction

    assign busy_o            = (state != IDLE);
    assign wr_bus.wr_ready_o = (state == IDLE) && (len_o < 5'(DEPTH));
    assign wr_acc            = wr_bus.wr_valid_i && wr_bus.wr_ready_o && !clear_i;
    assign prog_len          = clear_i ? 5'd0 : (wr_acc ? len_o + 5'd1 : len_o);
    // A write landing in slot 0 together with start must be played immediately.
    assign first_move        = (wr_acc && len_o == 5'd0) ? wr_bus.wr_data_i : mem[0];

    // Program buffer storage; contents survive across plays.
    always_ff @(posedge clk_i) begin
        if (rstn_i && wr_acc) begin
            mem[len_o[AW-1:0]] <= wr_bus.wr_data_i;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            len_o      <= '0;
            idx        <= '0;
            cube_cmd_o <= '0;
            finish_o   <= 1'b0;
            solved_o   <= 1'b0;
            moves_o    <= '0;
`ifdef RUBIK_SEQ_REPEAT_EN
            loops_o    <= '0;
`endif
        end else begin
            finish_o <= 1'b0;
            case (state)
                IDLE: begin
                    cube_cmd_o <= '0;
                    if (clear_i) begin
                        len_o <= '0;
                    end else if (wr_acc) begin
                        len_o <= len_o + 5'd1;
                    end
                    if (start_i) begin
                        solved_o <= 1'b0;
`ifdef RUBIK_SEQ_REPEAT_EN
                        loops_o  <= '0;
`endif
                        if (prog_len == 5'd0) begin
                            state   <= SETTLE;
                            idx     <= '0;
                            moves_o <= '0;
                        end else begin
                            state      <= RUN;
                            cube_cmd_o <= first_move;
                            idx        <= 5'd1;
                            moves_o    <= (first_move != 4'h0) ? 8'd1 : 8'd0;
                        end
                    end
                end
                RUN: begin
                    if (cube_done_i) begin
                        cube_cmd_o <= '0;
                        solved_o   <= 1'b1;
                        finish_o   <= 1'b1;
                        idx        <= '0;
                        state      <= IDLE;
                    end else if (idx == len_o) begin
                        cube_cmd_o <= '0;
                        state      <= SETTLE;
                    end else begin
                        cube_cmd_o <= mem[idx[AW-1:0]];
                        moves_o    <= count_move(moves_o, mem[idx[AW-1:0]]);
                        idx        <= idx + 5'd1;
                    end
                end
                SETTLE: begin
                    cube_cmd_o <= '0;
`ifdef RUBIK_SEQ_REPEAT_EN
                    loops_o <= loops_o + 4'd1;
                    if (!cube_done_i && (({1'b0, loops_o} + 5'd1) < 5'(MAX_LOOPS))) begin
                        // Next pass launches like a start: first move visible next cycle.
                        if (len_o != 5'd0) begin
                            state      <= RUN;
                            cube_cmd_o <= mem[0];
                            moves_o    <= count_move(moves_o, mem[0]);
                            idx        <= 5'd1;
                        end
                    end else begin
                        solved_o <= cube_done_i;
                        finish_o <= 1'b1;
                        idx      <= '0;
                        state    <= IDLE;
                    end
`else
                    solved_o <= cube_done_i;
                    finish_o <= 1'b1;
                    idx      <= '0;
                    state    <= IDLE;
`endif
                end
                default: begin
                    cube_cmd_o <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
